// File: rtl/lockin_reader_pkg.sv
// lockin_reader_pkg
//   Shared types and sizing helpers for lockin_result_reader and its FIFO.
//   Optional feature macro: LOCKIN_READER_TAG_EN (adds a tag word per record).
//   Contents:
//     rd_state_e         read serializer states (IDLE, TAG, FASE, CUAD)
//     TAG_W              width of each tag field (sequence / dropped count)
//     words_per_value    ceil(Q/W) bus words needed for one Q-bit value
//     words_per_record   bus words per complete record (fase + cuad [+ tag])
package lockin_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAG  = 2'd1,
        ST_FASE = 2'd2,
        ST_CUAD = 2'd3
    } rd_state_e;

    localparam int unsigned TAG_W = 16;

    function automatic int unsigned words_per_value(input int unsigned q, input int unsigned w);
        return (q + w - 1) / w;
    endfunction

    function automatic int unsigned words_per_record(input int unsigned q, input int unsigned w);
`ifdef LOCKIN_READER_TAG_EN
        return 2 * words_per_value(q, w) + 1;
`else
        return 2 * words_per_value(q, w);
`endif
    endfunction

endpackage

// File: rtl/sync_fifo_pair.sv
// sync_fifo_pair
//   Single-clock FIFO holding one lock-in record (cuad/fase pair, plus the
//   sequence tag when tagging is built in) per entry. First-word fall-through:
//   dout always shows the head record.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     push, din       write request and record; ignored while full unless a
//                     pop happens in the same cycle
//     pop             remove head record; ignored while empty
//     dout            head record
//     full, empty     derived from the registered level
//     level           number of stored records (0..DEPTH)
module sync_fifo_pair #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    import lockin_reader_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a push into a full
    // FIFO is still accepted when paired with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only read once level covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/lockin_result_reader.sv
// lockin_result_reader
//   Buffers (phase, quadrature) results from a lockin valid-only output and
//   serializes each record into W_BUS-bit words on a request/valid port.
//   Records arriving while the FIFO is full (and not being popped) are dropped
//   and flagged on the sticky overflow output.
//   Optional feature macro: LOCKIN_READER_TAG_EN -- each record is preceded by
//   a tag word {sequence number, dropped-record count}, both saturating.
//   Ports:
//     clk, reset_n          clock; reset_n is an asynchronous ACTIVE-HIGH reset
//     data_in_fase/_cuad    signed Q_sumas-bit results
//     data_in_valid         one-cycle strobe for the pair
//     rd_req                request next word
//     rd_data, rd_valid     registered word, valid one cycle after rd_req
//     empty, full, level    FIFO status (registered)
//     overflow              sticky drop flag, cleared by clear_overflow
module lockin_result_reader #(
    parameter int unsigned Q_sumas = 50,
    parameter int unsigned W_BUS   = 32,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [Q_sumas-1:0]      data_in_fase,
    input  logic [Q_sumas-1:0]      data_in_cuad,
    input  logic                    data_in_valid,
    input  logic                    rd_req,
    output logic [W_BUS-1:0]        rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    input  logic                    clear_overflow
);
    import lockin_reader_pkg::*;

    localparam int unsigned WPV   = words_per_value(Q_sumas, W_BUS);
    localparam int unsigned IW    = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int unsigned EXT_W = WPV * W_BUS;
`ifdef LOCKIN_READER_TAG_EN
    localparam int unsigned REC_W = 2 * Q_sumas + TAG_W;
`else
    localparam int unsigned REC_W = 2 * Q_sumas;
`endif

    rd_state_e          state_q, state_d;
    logic [IW-1:0]      widx_q, widx_d;
    logic [W_BUS-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               overflow_q, overflow_d;

    logic [REC_W-1:0]   rec_in, rec_head;
    logic               fifo_full, fifo_empty;
    logic               pop, drop, push_ok;
    logic               serve_fase, serve_cuad;

    logic signed [Q_sumas-1:0] fase_s, cuad_s;
    logic signed [EXT_W-1:0]   fase_ext, cuad_ext;

`ifdef LOCKIN_READER_TAG_EN
    logic [TAG_W-1:0]   seq_q, seq_d;
    logic [TAG_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               tag_rd;
    assign rec_in = {seq_q, data_in_cuad, data_in_fase};
`else
    assign rec_in = {data_in_cuad, data_in_fase};
`endif

    assign drop    = data_in_valid && fifo_full && !pop;
    assign push_ok = data_in_valid && !drop;

    sync_fifo_pair #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset_n),
        .push  (data_in_valid),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Size cast of a signed value sign-extends the top word to the bus width.
    assign fase_s   = rec_head[Q_sumas-1:0];
    assign cuad_s   = rec_head[2*Q_sumas-1:Q_sumas];
    assign fase_ext = EXT_W'(fase_s);
    assign cuad_ext = EXT_W'(cuad_s);

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        pop        = 1'b0;
        serve_fase = 1'b0;
        serve_cuad = 1'b0;
`ifdef LOCKIN_READER_TAG_EN
        tag_rd     = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (rd_req && !fifo_empty) begin
`ifdef LOCKIN_READER_TAG_EN
                    rd_valid_d = 1'b1;
                    rd_data_d  = W_BUS'({rec_head[REC_W-1 -: TAG_W], drop_cnt_q});
                    tag_rd     = 1'b1;
                    state_d    = ST_FASE;
                    widx_d     = '0;
`else
                    // Without a tag the first word is fase word 0, served
                    // by the shared FASE path below.
                    serve_fase = 1'b1;
`endif
                end
            end
            ST_FASE: serve_fase = rd_req;
            ST_CUAD: serve_cuad = rd_req;
            default: state_d = ST_IDLE;
        endcase

        if (serve_fase) begin
            rd_valid_d = 1'b1;
            rd_data_d  = fase_ext[widx_q*W_BUS +: W_BUS];
            if (widx_q == IW'(WPV - 1)) begin
                state_d = ST_CUAD;
                widx_d  = '0;
            end else begin
                state_d = ST_FASE;
                widx_d  = widx_q + IW'(1);
            end
        end

        if (serve_cuad) begin
            rd_valid_d = 1'b1;
            rd_data_d  = cuad_ext[widx_q*W_BUS +: W_BUS];
            if (widx_q == IW'(WPV - 1)) begin
                pop     = 1'b1;
                state_d = ST_IDLE;
                widx_d  = '0;
            end else begin
                widx_d  = widx_q + IW'(1);
            end
        end
    end

    always_comb begin
        // A drop in the same cycle wins over a clear request.
        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (clear_overflow)
            overflow_d = 1'b0;
    end

`ifdef LOCKIN_READER_TAG_EN
    always_comb begin
        seq_d      = seq_q;
        drop_cnt_d = tag_rd ? '0 : drop_cnt_q;
        if (push_ok && seq_q != '1)
            seq_d = seq_q + TAG_W'(1);
        if (drop && drop_cnt_d != '1)
            drop_cnt_d = drop_cnt_d + TAG_W'(1);
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            seq_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q    <= ST_IDLE;
            widx_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign overflow = overflow_q;
    assign empty    = fifo_empty;
    assign full     = fifo_full;

endmodule

// File: tb/tb_lockin_result_reader.sv
module tb_lockin_result_reader;

    localparam int unsigned Q     = 50;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WPV   = 2;
`ifdef LOCKIN_READER_TAG_EN
    localparam int unsigned WPR   = 2 * WPV + 1;
`else
    localparam int unsigned WPR   = 2 * WPV;
`endif
    localparam int unsigned TOFF  = WPR - 2 * WPV;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [Q-1:0]  data_in_fase = '0;
    logic [Q-1:0]  data_in_cuad = '0;
    logic          data_in_valid = 1'b0;
    logic          rd_req = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [3:0]    level;
    logic          overflow;
    logic          clear_overflow = 1'b0;

    lockin_result_reader #(
        .Q_sumas (Q),
        .W_BUS   (W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_in_fase   (data_in_fase),
        .data_in_cuad   (data_in_cuad),
        .data_in_valid  (data_in_valid),
        .rd_req         (rd_req),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .full           (full),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of records {seq, cuad, fase} plus the read
    // position within the head record.
    logic [115:0]  mq [$];
    int unsigned   rd_pos;
    bit            m_ovf;
    logic [15:0]   m_seq;
    logic [15:0]   m_drop;
    bit            e_valid;
    logic [31:0]   e_data;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] val_word(input logic [49:0] v, input int unsigned k);
        logic signed [49:0] s;
        longint x;
        s = v;
        x = longint'(s);
        return 32'(x >>> (32 * k));
    endfunction

    function automatic logic [31:0] rec_word(input logic [115:0] rec, input int unsigned pos);
        int unsigned p;
`ifdef LOCKIN_READER_TAG_EN
        if (pos == 0) return {rec[115:100], m_drop};
        p = pos - 1;
`else
        p = pos;
`endif
        if (p < WPV) return val_word(rec[49:0], p);
        return val_word(rec[99:50], p - WPV);
    endfunction

    task automatic model_reset();
        mq.delete();
        rd_pos = 0;
        m_ovf  = 1'b0;
        m_seq  = '0;
        m_drop = '0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(e_valid));
        if (e_valid) chk({tag, "_rd_data"}, 64'(rd_data), 64'(e_data));
        chk({tag, "_level"}, 64'(level), 64'(mq.size()));
        chk({tag, "_empty"}, 64'(empty), 64'(mq.size() == 0));
        chk({tag, "_full"}, 64'(full), 64'(mq.size() == DEPTH));
        chk({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
    endtask

    task automatic step(input bit vld, input logic [49:0] f, input logic [49:0] c,
                        input bit req, input bit clr, input string tag);
        bit pop;
        bit drop;
        bit tagrd;
        data_in_valid  = vld;
        data_in_fase   = f;
        data_in_cuad   = c;
        rd_req         = req;
        clear_overflow = clr;
        @(posedge clk);
        pop = 0; tagrd = 0; e_valid = 0;
        if (req && mq.size() > 0) begin
            e_valid = 1;
            e_data  = rec_word(mq[0], rd_pos);
            if (TOFF == 1 && rd_pos == 0) tagrd = 1;
            rd_pos++;
            if (rd_pos == WPR) begin
                rd_pos = 0;
                pop = 1;
            end
        end
        drop = vld && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (vld && !drop) begin
            mq.push_back({m_seq, c, f});
            if (m_seq != 16'hFFFF) m_seq++;
        end
        if (tagrd) m_drop = '0;
        if (drop && m_drop != 16'hFFFF) m_drop++;
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        #1;
        check_status(tag);
        data_in_valid  = 1'b0;
        rd_req         = 1'b0;
        clear_overflow = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n        = 1'b1;
        rd_req         = 1'b1;
        data_in_valid  = 1'b1;
        data_in_fase   = 50'h1234;
        clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        e_valid = 0;
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        check_status("rst");
        reset_n       = 1'b0;
        rd_req        = 1'b0;
        data_in_valid = 1'b0;
    endtask

    function automatic logic [49:0] rnd50();
        return 50'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [31:0] exp_words [4];
        int guard;
        exp_words[0] = 32'h23456789;
        exp_words[1] = 32'h00000001;
        exp_words[2] = 32'hFFFFFFFF;
        exp_words[3] = 32'hFFFFFFFF;

        apply_reset();

        // Requests while empty are ignored.
        for (int i = 0; i < 10; i++) step(0, '0, '0, 1, 0, "empty_req");

        // Single known record with sign extension of both values.
        step(1, 50'h0_0001_2345_6789, '1, 0, 0, "single_push");
        for (int unsigned k = 0; k < WPR; k++) begin
            step(0, '0, '0, 1, 0, "single_rd");
            if (k >= TOFF) chk("single_const_word", 64'(rd_data), 64'(exp_words[k - TOFF]));
        end
        chk("single_empty_after", 64'(empty), 64'(1));

        // Ordering: three consecutive pushes, then read all.
        for (int i = 0; i < 3; i++) step(1, rnd50(), rnd50(), 0, 0, "ord_push");
        chk("ord_level3", 64'(level), 64'(3));
        for (int unsigned i = 0; i < 3 * WPR; i++) step(0, '0, '0, 1, 0, "ord_rd");

        // Overflow: nine pushes without reads.
        for (int i = 0; i < 9; i++) step(1, rnd50(), rnd50(), 0, 0, "ovf_push");
        chk("ovf_full", 64'(full), 64'(1));
        chk("ovf_level8", 64'(level), 64'(8));
        chk("ovf_flag", 64'(overflow), 64'(1));
        step(0, '0, '0, 0, 1, "ovf_clear");
        chk("ovf_cleared", 64'(overflow), 64'(0));

        // Push coincident with the pop of a full FIFO.
        for (int unsigned i = 0; i < WPR - 1; i++) step(0, '0, '0, 1, 0, "fullpop_rd");
        step(1, rnd50(), rnd50(), 1, 0, "fullpop");
        chk("fullpop_level8", 64'(level), 64'(8));
        chk("fullpop_no_ovf", 64'(overflow), 64'(0));

        guard = 0;
        while ((mq.size() > 0 || rd_pos != 0) && guard < 200) begin
            step(0, '0, '0, 1, 0, "drain1");
            guard++;
        end
        chk("drain1_done", 64'(mq.size()), 64'(0));

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 9) < 4), rnd50(), rnd50(),
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) == 0), "rand");

        guard = 0;
        while ((mq.size() > 0 || rd_pos != 0) && guard < 200) begin
            step(0, '0, '0, 1, 0, "drain2");
            guard++;
        end
        chk("drain2_done", 64'(mq.size()), 64'(0));

        // Reset in the middle of a record.
        step(1, rnd50(), rnd50(), 0, 0, "mid_push");
        step(1, rnd50(), rnd50(), 0, 0, "mid_push");
        step(0, '0, '0, 1, 0, "mid_rd");
        step(0, '0, '0, 1, 0, "mid_rd");
        apply_reset();
        chk("mid_level0", 64'(level), 64'(0));
        chk("mid_empty", 64'(empty), 64'(1));
        step(1, rnd50(), rnd50(), 0, 0, "post_push");
        for (int unsigned i = 0; i < WPR; i++) step(0, '0, '0, 1, 0, "post_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
